// File: rtl/isa_bus_master.sv
// CPU-side ISA bus initiator: turns one CPU request into a single ISA I/O or memory
// cycle (ALE, AEN, command strobe), honouring IOCHRDY wait states with a timeout.
module isa_bus_master #(
    parameter int unsigned CMD_MIN_CYCLES  = 4,
    parameter int unsigned RECOVERY_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic        clk_bus,
    input  logic        busreset_l,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_io,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic        cpu_timeout,
    output logic [7:0]  cpu_rdata,
    output logic [19:0] bus_a,
    output logic [15:0] bus_d,
    input  logic [7:0]  bus_in,
    input  logic        bus_dir,
    input  logic        bus_rdy,
    output logic        bus_ale,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l
);

    localparam int unsigned CNT_MAX_A = (CMD_MIN_CYCLES > TIMEOUT_CYCLES) ? CMD_MIN_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RECOVERY_CYCLES) ? CNT_MAX_A : RECOVERY_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned AW        = 20;
    localparam int unsigned DW        = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_CMD     = 3'd2,
        S_WAIT    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             lat_we, lat_io, nxt_we, nxt_io;
    logic [AW-1:0]    nxt_bus_a;
    logic [2*DW-1:0]  nxt_bus_d;
    logic [DW-1:0]    nxt_rdata;
    logic             nxt_ack, nxt_timeout;
    logic             finish, timed_out, strobe_on;
    logic             nxt_ior_l, nxt_iow_l, nxt_memr_l, nxt_memw_l;

    // Next-state and next-output decode; outputs are derived from the state being entered
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_we      = lat_we;
        nxt_io      = lat_io;
        nxt_bus_a   = bus_a;
        nxt_bus_d   = bus_d;
        nxt_rdata   = cpu_rdata;
        nxt_ack     = 1'b0;
        nxt_timeout = 1'b0;
        finish      = 1'b0;
        timed_out   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    nxt_state = S_ADDR;
                    nxt_we    = cpu_we;
                    nxt_io    = cpu_io;
                    nxt_bus_a = cpu_addr;
                    nxt_bus_d = cpu_we ? {8'h00, cpu_wdata} : 16'h0000;
                    nxt_cnt   = '0;
                end
            end
            S_ADDR: begin
                nxt_state = S_CMD;
                nxt_cnt   = CNT_W'(1);
            end
            S_CMD: begin
                if (cnt == CNT_W'(CMD_MIN_CYCLES)) begin
                    if (bus_rdy) begin
                        finish = 1'b1;
                    end else begin
                        nxt_state = S_WAIT;
                        nxt_cnt   = '0;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (bus_rdy) begin
                    finish = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (cnt == CNT_W'(RECOVERY_CYCLES - 1)) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                    nxt_bus_d = 16'h0000;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase

        // Read data is captured on the edge that leaves CMD/WAIT
        if (finish) begin
            nxt_state   = S_RECOVER;
            nxt_cnt     = '0;
            nxt_ack     = 1'b1;
            nxt_timeout = timed_out;
            if (!lat_we) begin
                nxt_rdata = (bus_dir && !timed_out) ? bus_in : 8'hFF;
            end
        end

        strobe_on  = (nxt_state == S_CMD) || (nxt_state == S_WAIT);
        nxt_ior_l  = !(strobe_on &&  nxt_io && !nxt_we);
        nxt_iow_l  = !(strobe_on &&  nxt_io &&  nxt_we);
        nxt_memr_l = !(strobe_on && !nxt_io && !nxt_we);
        nxt_memw_l = !(strobe_on && !nxt_io &&  nxt_we);
    end

    // State and registered outputs
    always_ff @(posedge clk_bus or negedge busreset_l) begin
        if (!busreset_l) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_io      <= 1'b0;
            cpu_busy    <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_timeout <= 1'b0;
            cpu_rdata   <= 8'hFF;
            bus_a       <= '0;
            bus_d       <= '0;
            bus_ale     <= 1'b0;
            bus_aen     <= 1'b1;
            bus_ior_l   <= 1'b1;
            bus_iow_l   <= 1'b1;
            bus_memr_l  <= 1'b1;
            bus_memw_l  <= 1'b1;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            lat_we      <= nxt_we;
            lat_io      <= nxt_io;
            cpu_busy    <= (nxt_state != S_IDLE);
            cpu_ack     <= nxt_ack;
            cpu_timeout <= nxt_timeout;
            cpu_rdata   <= nxt_rdata;
            bus_a       <= nxt_bus_a;
            bus_d       <= nxt_bus_d;
            bus_ale     <= (nxt_state == S_ADDR);
            bus_aen     <= (nxt_state == S_IDLE);
            bus_ior_l   <= nxt_ior_l;
            bus_iow_l   <= nxt_iow_l;
            bus_memr_l  <= nxt_memr_l;
            bus_memw_l  <= nxt_memw_l;
        end
    end

endmodule
